// File: rtl/key_pkg.sv
// Shared types and width helpers for the multi-channel key conditioner.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DOWN = 3'd1,
    DOWN      = 3'd2,
    HOLD      = 3'd3,
    WAIT_UP   = 3'd4
  } key_state_e;

  function automatic int unsigned max_fn(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned clog2_fn(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Counter must hold every terminal value, so size it for the largest period.
  function automatic int unsigned cnt_width(input int unsigned d, input int unsigned l,
                                            input int unsigned r);
    return clog2_fn(max_fn(d, max_fn(l, r)) + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser, debounce/long-press/repeat FSM and shared counter.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_state,
  output logic press_down,
  output logic press_up,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
  localparam logic RELEASED  = (ACTIVE_LOW != 0);
  localparam logic REPEAT_EN = (REPEAT_CYCLES != 0);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  key_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   long_done_q, long_done_d;
  logic                   key_state_q, key_state_d;
  logic                   press_down_q, press_down_d;
  logic                   press_up_q, press_up_d;
  logic                   long_press_q, long_press_d;
  logic                   repeat_pulse_q, repeat_pulse_d;
  logic                   pressed;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], key_in};
    pressed = sync_q[SYNC_STAGES-1] ^ RELEASED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q         <= {SYNC_STAGES{RELEASED}};
      state_q        <= IDLE;
      cnt_q          <= '0;
      long_done_q    <= 1'b0;
      key_state_q    <= 1'b0;
      press_down_q   <= 1'b0;
      press_up_q     <= 1'b0;
      long_press_q   <= 1'b0;
      repeat_pulse_q <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      long_done_q    <= long_done_d;
      key_state_q    <= key_state_d;
      press_down_q   <= press_down_d;
      press_up_q     <= press_up_d;
      long_press_q   <= long_press_d;
      repeat_pulse_q <= repeat_pulse_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    long_done_d = long_done_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pressed) state_d = WAIT_DOWN;
      end
      WAIT_DOWN: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == D_LAST) begin
          state_d     = DOWN;
          cnt_d       = '0;
          long_done_d = 1'b0;
        end
      end
      DOWN: begin
        if (!pressed) begin
          state_d = WAIT_UP;
          cnt_d   = '0;
        end else if (cnt_q == L_LAST) begin
          state_d     = HOLD;
          cnt_d       = '0;
          long_done_d = 1'b1;
        end
      end
      HOLD: begin
        // With repeat disabled the counter parks instead of running past its width.
        if (!pressed) begin
          state_d = WAIT_UP;
          cnt_d   = '0;
        end else if (!REPEAT_EN) begin
          cnt_d = cnt_q;
        end else if (cnt_q == R_LAST) begin
          cnt_d = '0;
        end
      end
      WAIT_UP: begin
        if (pressed) begin
          state_d = long_done_q ? HOLD : DOWN;
          cnt_d   = '0;
        end else if (cnt_q == D_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        long_done_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    key_state_d    = (state_d == DOWN) || (state_d == HOLD) || (state_d == WAIT_UP);
    press_down_d   = (state_q == WAIT_DOWN) && (state_d == DOWN);
    press_up_d     = (state_q == WAIT_UP) && (state_d == IDLE);
    long_press_d   = (state_q == DOWN) && (state_d == HOLD);
    repeat_pulse_d = REPEAT_EN && (state_q == HOLD) && pressed && (cnt_q == R_LAST);
  end

  assign key_state    = key_state_q;
  assign press_down   = press_down_q;
  assign press_up     = press_up_q;
  assign long_press   = long_press_q;
  assign repeat_pulse = repeat_pulse_q;

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel key conditioner: NUM_KEYS independent key_debounce_ch instances.
module key_debounce_multi #(
  parameter int NUM_KEYS        = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press_down,
  output logic [NUM_KEYS-1:0] press_up,
  output logic [NUM_KEYS-1:0] long_press,
  output logic [NUM_KEYS-1:0] repeat_pulse
);

  if (NUM_KEYS < 1) begin : g_bad_num_keys
    $error("key_debounce_multi: NUM_KEYS must be >= 1");
  end
  if ((ACTIVE_LOW != 0) && (ACTIVE_LOW != 1)) begin : g_bad_active_low
    $error("key_debounce_multi: ACTIVE_LOW must be 0 or 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("key_debounce_multi: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_debounce_multi: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("key_debounce_multi: LONG_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 0) begin : g_bad_repeat
    $error("key_debounce_multi: REPEAT_CYCLES must be >= 0");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_in       (key_in[i]),
      .key_state    (key_state[i]),
      .press_down   (press_down[i]),
      .press_up     (press_up[i]),
      .long_press   (long_press[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench: directed timing scenarios plus random key activity against a run-length reference model.
module tb_key_debounce_multi;

  localparam int NK = 2;
  localparam int AL = 1;
  localparam int S  = 2;
  localparam int D  = 4;
  localparam int L  = 20;
  localparam int R  = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] ks_a, pd_a, pu_a, lp_a, rp_a;
  logic [NK-1:0] ks_b, pd_b, pu_b, lp_b, rp_b;

  always #5 clk = ~clk;

  key_debounce_multi #(
    .NUM_KEYS(NK), .ACTIVE_LOW(AL), .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_state(ks_a), .press_down(pd_a), .press_up(pu_a),
    .long_press(lp_a), .repeat_pulse(rp_a)
  );

  key_debounce_multi #(
    .NUM_KEYS(NK), .ACTIVE_LOW(AL), .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(0)
  ) dut_norep (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_state(ks_b), .press_down(pd_b), .press_up(pu_b),
    .long_press(lp_b), .repeat_pulse(rp_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level change is accepted once the synchronised level has
  // disagreed with the accepted level for D+1 consecutive edges; hold/repeat
  // timers restart on any released edge.
  int rep_len [2] = '{R, 0};
  bit dq      [NK][$];
  int run     [2][NK];
  int h       [2][NK];
  int r       [2][NK];
  bit acc     [2][NK];
  bit ld      [2][NK];
  bit e_pd    [2][NK];
  bit e_pu    [2][NK];
  bit e_lp    [2][NK];
  bit e_rp    [2][NK];

  task automatic model_reset();
    for (int c = 0; c < NK; c++) begin
      dq[c].delete();
      for (int k = 0; k < S; k++) dq[c].push_back(1'b0);
      for (int i = 0; i < 2; i++) begin
        run[i][c] = 0; h[i][c] = 0; r[i][c] = 0;
        acc[i][c] = 0; ld[i][c] = 0;
        e_pd[i][c] = 0; e_pu[i][c] = 0; e_lp[i][c] = 0; e_rp[i][c] = 0;
      end
    end
  endtask

  task automatic model_chan(input int i, input int c, input bit p);
    e_pd[i][c] = 0; e_pu[i][c] = 0; e_lp[i][c] = 0; e_rp[i][c] = 0;
    if (!acc[i][c]) begin
      if (p) begin
        run[i][c]++;
        if (run[i][c] == D + 1) begin
          acc[i][c] = 1; e_pd[i][c] = 1; run[i][c] = 0; h[i][c] = 0; ld[i][c] = 0;
        end
      end else begin
        run[i][c] = 0;
      end
    end else if (!p) begin
      run[i][c]++;
      h[i][c] = -1;
      r[i][c] = -1;
      if (run[i][c] == D + 1) begin
        acc[i][c] = 0; e_pu[i][c] = 1; run[i][c] = 0;
      end
    end else begin
      run[i][c] = 0;
      if (!ld[i][c]) begin
        h[i][c]++;
        if (h[i][c] == L) begin
          e_lp[i][c] = 1; ld[i][c] = 1; r[i][c] = 0;
        end
      end else if (rep_len[i] != 0) begin
        r[i][c]++;
        if (r[i][c] == rep_len[i]) begin
          e_rp[i][c] = 1; r[i][c] = 0;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int c = 0; c < NK; c++) begin
        bit p;
        p = dq[c].pop_front();
        dq[c].push_back(key_in[c] ^ (AL != 0));
        for (int i = 0; i < 2; i++) model_chan(i, c, p);
      end
    end
  end

  function automatic logic [NK-1:0] pack(input bit v [NK]);
    logic [NK-1:0] o;
    for (int c = 0; c < NK; c++) o[c] = v[c];
    return o;
  endfunction

  always @(posedge clk) begin
    #2;
    check("model_key_state_a",    ks_a, pack(acc[0]));
    check("model_press_down_a",   pd_a, pack(e_pd[0]));
    check("model_press_up_a",     pu_a, pack(e_pu[0]));
    check("model_long_press_a",   lp_a, pack(e_lp[0]));
    check("model_repeat_pulse_a", rp_a, pack(e_rp[0]));
    check("model_key_state_b",    ks_b, pack(acc[1]));
    check("model_press_down_b",   pd_b, pack(e_pd[1]));
    check("model_press_up_b",     pu_b, pack(e_pu[1]));
    check("model_long_press_b",   lp_b, pack(e_lp[1]));
    check("model_repeat_pulse_b", rp_b, pack(e_rp[1]));
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {ks_a, pd_a, pu_a, lp_a}, 8'h00);
    check(name, {rp_a, ks_b, pd_b, pu_b}, 8'h00);
  endtask

  bit lvl [NK];
  int rem [NK];
  int lp_count;

  initial begin
    model_reset();
    key_in = '1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("lit_reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean long press on key 0 with repeats, then clean release.
    key_in = 2'b10;
    wait_edges(6);
    check("lit_pd_edge6", pd_a, 2'b00);
    check("lit_ks_edge6", ks_a, 2'b00);
    wait_edges(1);
    check("lit_pd_edge7", pd_a, 2'b01);
    check("lit_ks_edge7", ks_a, 2'b01);
    check("lit_pd_edge7_norep", pd_b, 2'b01);
    wait_edges(1);
    check("lit_pd_edge8", pd_a, 2'b00);
    check("lit_ks_edge8", ks_a, 2'b01);
    wait_edges(19);
    check("lit_lp_edge27", lp_a, 2'b01);
    check("lit_lp_edge27_norep", lp_b, 2'b01);
    wait_edges(5);
    check("lit_rp_edge32", rp_a, 2'b01);
    check("lit_rp_edge32_norep", rp_b, 2'b00);
    wait_edges(5);
    check("lit_rp_edge37", rp_a, 2'b01);
    wait_edges(5);
    check("lit_rp_edge42", rp_a, 2'b01);
    @(negedge clk);
    key_in = 2'b11;
    wait_edges(6);
    check("lit_pu_edge6", pu_a, 2'b00);
    check("lit_ks_rel_edge6", ks_a, 2'b01);
    wait_edges(1);
    check("lit_pu_edge7", pu_a, 2'b01);
    check("lit_ks_rel_edge7", ks_a, 2'b00);
    wait_edges(3);

    // Press bounce: three low samples only.
    @(negedge clk);
    key_in = 2'b10;
    wait_edges(3);
    @(negedge clk);
    key_in = 2'b11;
    wait_edges(10);
    check("lit_bounce_ks", ks_a, 2'b00);

    // Release bounce from DOWN.
    @(negedge clk);
    key_in = 2'b10;
    wait_edges(7);
    check("lit_pd_after_bounce", pd_a, 2'b01);
    wait_edges(2);
    @(negedge clk);
    key_in = 2'b11;
    wait_edges(2);
    @(negedge clk);
    key_in = 2'b10;
    wait_edges(10);
    check("lit_rel_bounce_ks", ks_a, 2'b01);
    @(negedge clk);
    key_in = 2'b11;
    wait_edges(7);
    check("lit_pu_after_rel_bounce", pu_a, 2'b01);
    wait_edges(3);

    // Release bounce after long press must not re-fire long_press.
    @(negedge clk);
    key_in = 2'b10;
    wait_edges(27);
    check("lit_lp_before_wait_up_bounce", lp_a, 2'b01);
    @(negedge clk);
    key_in = 2'b11;
    wait_edges(2);
    @(negedge clk);
    key_in = 2'b10;
    lp_count = 0;
    repeat (25) begin
      wait_edges(1);
      if (lp_a[0]) lp_count++;
    end
    check("lit_no_second_long", 8'(lp_count), 8'd0);
    @(negedge clk);
    key_in = 2'b11;
    wait_edges(10);

    // Simultaneous press on both keys, then reset while in HOLD.
    @(negedge clk);
    key_in = 2'b00;
    wait_edges(7);
    check("lit_pd_both", pd_a, 2'b11);
    check("lit_pd_both_norep", pd_b, 2'b11);
    wait_edges(22);
    check("lit_ks_both_hold", ks_a, 2'b11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("lit_reset_in_hold");
    @(negedge clk);
    rst_n = 1'b1;
    wait_edges(6);
    check("lit_pd_post_reset_edge6", pd_a, 2'b00);
    wait_edges(1);
    check("lit_pd_post_reset_edge7", pd_a, 2'b11);
    check("lit_ks_post_reset_edge7", ks_a, 2'b11);
    @(negedge clk);
    key_in = 2'b11;
    wait_edges(10);

    // Reset during WAIT_DOWN with the key still held.
    @(negedge clk);
    key_in = 2'b10;
    wait_edges(4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("lit_reset_in_wait_down");
    @(negedge clk);
    rst_n = 1'b1;
    wait_edges(7);
    check("lit_pd_after_wd_reset", pd_a, 2'b01);
    @(negedge clk);
    key_in = 2'b11;
    wait_edges(10);

    // Random activity with mixed bounce and long holds plus occasional resets.
    for (int c = 0; c < NK; c++) begin
      lvl[c] = 0;
      rem[c] = 0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < NK; c++) begin
        if (rem[c] == 0) begin
          lvl[c] = ~lvl[c];
          rem[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(5, 70);
        end else begin
          rem[c]--;
        end
        key_in[c] = (AL != 0) ? ~lvl[c] : lvl[c];
      end
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    key_in = '1;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
